// File: rtl/fpu_arb_pkg.sv
// Shared types and constants for the fsub issue arbiter and its result FIFOs.
package fpu_arb_pkg;

   localparam int LAT_DEF = 3;
   localparam int ID_W = 1;

   localparam logic OP_SUB = 1'b0;
   localparam logic OP_ADD = 1'b1;

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic    v;
      req_id_t id;
   } tag_t;

   // fadd is x1 - (-x2), so an add only needs the x2 sign inverted
   function automatic logic [31:0] fu_operand2(input logic [31:0] x2, input logic op);
      return {x2[31] ^ (op == OP_ADD), x2[30:0]};
   endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Per-requester result FIFO holding {ovf, y}; output reads zero when empty.
module fpu_result_fifo #(
   parameter int DEPTH = 4,
   parameter int CW    = 3,
   parameter int DW    = 33
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic          valid,
   output logic [DW-1:0] data,
   output logic [CW-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_pop;

   assign valid  = rstn && (count != '0);
   assign data   = valid ? mem[rd_ptr] : '0;
   assign do_pop = pop && valid;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Credits in the arbiter make a push into a full FIFO impossible.
   always_ff @(posedge clk) begin
      if (rstn && push) begin
         push_when_full: assert (count != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/fsub_issue_arb.sv
// Round-robin, credit-gated issue of two requesters onto one non-stallable
// pipelined fsub unit, with results steered back through per-requester FIFOs.
module fsub_issue_arb
   import fpu_arb_pkg::*;
#(
   parameter int LAT   = LAT_DEF,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic        clk,
   input  logic        rstn,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic        req0_op,
   input  logic [31:0] req0_x1,
   input  logic [31:0] req0_x2,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic        req1_op,
   input  logic [31:0] req1_x1,
   input  logic [31:0] req1_x2,

   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic [31:0] resp0_y,
   output logic        resp0_ovf,

   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp1_y,
   output logic        resp1_ovf,

   output logic [31:0] fu_x1,
   output logic [31:0] fu_x2,
   input  logic [31:0] fu_y,
   input  logic        fu_ovf
);

   logic [CW:0]   credit0;
   logic [CW:0]   credit1;
   logic [CW-1:0] cnt0;
   logic [CW-1:0] cnt1;
   logic [CW-1:0] infl0;
   logic [CW-1:0] infl1;
   logic          elig0;
   logic          elig1;
   logic          grant0;
   logic          grant1;
   logic          issue;
   req_id_t       gid;
   req_id_t       last_id;
   tag_t          tags [LAT];
   logic          push0;
   logic          push1;
   logic [32:0]   rdata0;
   logic [32:0]   rdata1;

   // Everything already owed to a requester (queued or in the fsub) consumes a credit.
   assign credit0 = (CW+1)'(DEPTH) - {1'b0, cnt0} - {1'b0, infl0};
   assign credit1 = (CW+1)'(DEPTH) - {1'b0, cnt1} - {1'b0, infl1};

   assign elig0 = rstn && req0_valid && (credit0 != '0);
   assign elig1 = rstn && req1_valid && (credit1 != '0);

   assign grant0 = elig0 && (!elig1 || (last_id == req_id_t'(1)));
   assign grant1 = elig1 && (!elig0 || (last_id == req_id_t'(0)));

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign issue      = grant0 || grant1;
   assign gid        = req_id_t'(grant1);

   always_comb begin
      fu_x1 = '0;
      fu_x2 = '0;
      if (grant0) begin
         fu_x1 = req0_x1;
         fu_x2 = fu_operand2(req0_x2, req0_op);
      end else if (grant1) begin
         fu_x1 = req1_x1;
         fu_x2 = fu_operand2(req1_x2, req1_op);
      end
   end

   // Tag pipe mirrors the fsub latency so the result owner is known at the output.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int k = 0; k < LAT; k++) begin
            tags[k] <= '0;
         end
         last_id <= req_id_t'(1);
      end else begin
         tags[0] <= {issue, gid};
         for (int k = 1; k < LAT; k++) begin
            tags[k] <= tags[k-1];
         end
         if (issue) begin
            last_id <= gid;
         end
      end
   end

   assign push0 = tags[LAT-1].v && (tags[LAT-1].id == req_id_t'(0));
   assign push1 = tags[LAT-1].v && (tags[LAT-1].id == req_id_t'(1));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         infl0 <= '0;
         infl1 <= '0;
      end else begin
         infl0 <= infl0 + CW'(grant0) - CW'(push0);
         infl1 <= infl1 + CW'(grant1) - CW'(push1);
      end
   end

   fpu_result_fifo #(.DEPTH(DEPTH), .CW(CW), .DW(33)) u_fifo0 (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push0),
      .push_data ({fu_ovf, fu_y}),
      .pop       (resp0_ready),
      .valid     (resp0_valid),
      .data      (rdata0),
      .count     (cnt0)
   );

   fpu_result_fifo #(.DEPTH(DEPTH), .CW(CW), .DW(33)) u_fifo1 (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push1),
      .push_data ({fu_ovf, fu_y}),
      .pop       (resp1_ready),
      .valid     (resp1_valid),
      .data      (rdata1),
      .count     (cnt1)
   );

   assign {resp0_ovf, resp0_y} = rdata0;
   assign {resp1_ovf, resp1_y} = rdata1;

endmodule

// File: tb/tb_fsub_issue_arb.sv
// Bench for fsub_issue_arb: stand-in fsub pipeline, queue-based reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fsub_issue_arb;
   import fpu_arb_pkg::*;

   localparam int DEPTH = 4;
   localparam int TLAT  = 3;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0_valid, req0_ready, req0_op;
   logic [31:0] req0_x1, req0_x2;
   logic        req1_valid, req1_ready, req1_op;
   logic [31:0] req1_x1, req1_x2;
   logic        resp0_valid, resp0_ready, resp0_ovf;
   logic [31:0] resp0_y;
   logic        resp1_valid, resp1_ready, resp1_ovf;
   logic [31:0] resp1_y;
   logic [31:0] fu_x1, fu_x2, fu_y;
   logic        fu_ovf;

   always #5 clk = ~clk;

   fsub_issue_arb #(.LAT(TLAT), .DEPTH(DEPTH), .CW(3)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_x1(req0_x1), .req0_x2(req0_x2),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_x1(req1_x1), .req1_x2(req1_x2),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_y(resp0_y), .resp0_ovf(resp0_ovf),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_y(resp1_y), .resp1_ovf(resp1_ovf),
      .fu_x1(fu_x1), .fu_x2(fu_x2), .fu_y(fu_y), .fu_ovf(fu_ovf)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [32:0] got, input logic [32:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Stand-in fsub: known IEEE cases from a table, otherwise a fixed scramble.
   function automatic logic [32:0] fsub_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h40400000 && b == 32'h3F800000) return {1'b0, 32'h40000000};
      if (a == 32'h3F800000 && b == 32'hBF800000) return {1'b0, 32'h40000000};
      if (a == 32'h7F7FFFFF && b == 32'hFF7FFFFF) return {1'b1, 32'h7F800000};
      return {^(a ^ b), a ^ {b[15:0], b[31:16]} ^ 32'h12345678};
   endfunction

   logic [32:0] fp [TLAT];
   always @(posedge clk) begin
      fp[0] <= fsub_fn(fu_x1, fu_x2);
      for (int k = 1; k < TLAT; k++) fp[k] <= fp[k-1];
   end
   assign fu_y   = fp[TLAT-1][31:0];
   assign fu_ovf = fp[TLAT-1][32];

   typedef struct {
      int          id;
      logic [32:0] d;
      int          age;
   } pend_t;

   pend_t       pend[$];
   logic [32:0] fq[2][$];
   int          outst[2];
   int          last_g;

   initial begin : model
      int          g;
      bit          elig[2];
      bit          rv[2];
      bit          pop[2];
      logic [31:0] x1[2];
      logic [31:0] fx2[2];
      logic [32:0] d;
      logic [32:0] ed[2];
      last_g   = 1;
      outst[0] = 0;
      outst[1] = 0;
      forever begin
         @(negedge clk);
         x1[0]   = req0_x1;
         x1[1]   = req1_x1;
         fx2[0]  = {req0_x2[31] ^ req0_op, req0_x2[30:0]};
         fx2[1]  = {req1_x2[31] ^ req1_op, req1_x2[30:0]};
         elig[0] = rstn && req0_valid && (outst[0] < DEPTH);
         elig[1] = rstn && req1_valid && (outst[1] < DEPTH);
         g = -1;
         if (elig[0] && elig[1]) g = 1 - last_g;
         else if (elig[0]) g = 0;
         else if (elig[1]) g = 1;
         chk("m_req0_ready", 33'(req0_ready), 33'(g == 0));
         chk("m_req1_ready", 33'(req1_ready), 33'(g == 1));
         chk("m_fu_x1", 33'(fu_x1), (g < 0) ? 33'(0) : 33'(x1[g]));
         chk("m_fu_x2", 33'(fu_x2), (g < 0) ? 33'(0) : 33'(fx2[g]));
         for (int i = 0; i < 2; i++) begin
            rv[i] = rstn && (fq[i].size() > 0);
            ed[i] = rv[i] ? fq[i][0] : 33'(0);
         end
         chk("m_resp0_valid", 33'(resp0_valid), 33'(rv[0]));
         chk("m_resp1_valid", 33'(resp1_valid), 33'(rv[1]));
         chk("m_resp0_data", {resp0_ovf, resp0_y}, ed[0]);
         chk("m_resp1_data", {resp1_ovf, resp1_y}, ed[1]);
         pop[0] = rv[0] && resp0_ready;
         pop[1] = rv[1] && resp1_ready;
         d = (g < 0) ? 33'(0) : fsub_fn(x1[g], fx2[g]);
         @(posedge clk);
         if (!rstn) begin
            pend.delete();
            fq[0].delete();
            fq[1].delete();
            outst[0] = 0;
            outst[1] = 0;
            last_g   = 1;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (pop[i]) begin
                  void'(fq[i].pop_front());
                  outst[i]--;
               end
            end
            foreach (pend[k]) pend[k].age++;
            while (pend.size() > 0 && pend[0].age >= TLAT) begin
               fq[pend[0].id].push_back(pend[0].d);
               void'(pend.pop_front());
            end
            if (g >= 0) begin
               pend.push_back('{g, d, 0});
               outst[g]++;
               last_g = g;
            end
         end
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b);
      req0_valid = v; req0_op = op; req0_x1 = a; req0_x2 = b;
   endtask

   task automatic drive1(input logic v, input logic op, input logic [31:0] a, input logic [31:0] b);
      req1_valid = v; req1_op = op; req1_x1 = a; req1_x2 = b;
   endtask

   initial begin : stim
      int n0;
      int n1;
      rstn = 1'b0;
      resp0_ready = 1'b1;
      resp1_ready = 1'b1;
      drive0(1'b1, OP_SUB, 32'h0, 32'h0);
      drive1(1'b0, OP_SUB, 32'h0, 32'h0);
      @(negedge clk);
      chk("rst_req0_ready", 33'(req0_ready), 33'(0));
      chk("rst_resp0_valid", 33'(resp0_valid), 33'(0));
      chk("rst_resp1_data", {resp1_ovf, resp1_y}, 33'(0));
      next_cyc();
      next_cyc();
      rstn = 1'b1;
      req0_valid = 1'b0;
      next_cyc();

      // subtract on requester 0
      drive0(1'b1, OP_SUB, 32'h40400000, 32'h3F800000);
      @(negedge clk);
      chk("sub_ready", 33'(req0_ready), 33'(1));
      chk("sub_fu_x2", 33'(fu_x2), 33'h3F800000);
      next_cyc();
      req0_valid = 1'b0;
      next_cyc();
      next_cyc();
      @(negedge clk);
      chk("sub_not_early", 33'(resp0_valid), 33'(0));
      next_cyc();
      @(negedge clk);
      chk("sub_valid", 33'(resp0_valid), 33'(1));
      chk("sub_result", {resp0_ovf, resp0_y}, {1'b0, 32'h40000000});
      next_cyc();

      // add on requester 1
      drive1(1'b1, OP_ADD, 32'h3F800000, 32'h3F800000);
      @(negedge clk);
      chk("add_ready", 33'(req1_ready), 33'(1));
      chk("add_fu_x2", 33'(fu_x2), 33'hBF800000);
      next_cyc();
      req1_valid = 1'b0;
      repeat (3) next_cyc();
      @(negedge clk);
      chk("add_result", {resp1_valid, resp1_y}, {1'b1, 32'h40000000});
      next_cyc();

      // round robin with both requesters streaming
      for (int k = 0; k < 8; k++) begin
         drive0(1'b1, OP_SUB, 32'h41000000 + k, 32'h3F000000 + k);
         drive1(1'b1, OP_ADD, 32'h42000000 + k, 32'h3E000000 + k);
         @(negedge clk);
         chk("rr_grant0", 33'(req0_ready), 33'((k % 2) == 0));
         chk("rr_grant1", 33'(req1_ready), 33'((k % 2) == 1));
         next_cyc();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (6) next_cyc();

      // backpressure on requester 0
      resp0_ready = 1'b0;
      n0 = 0;
      n1 = 0;
      for (int k = 0; k < 12; k++) begin
         drive0(1'b1, OP_SUB, 32'h40800000 + k, 32'h3F800000);
         drive1(1'b1, OP_SUB, 32'h40A00000 + k, 32'h3F800000 + k);
         @(negedge clk);
         n0 += int'(req0_ready);
         if (k >= 7 && k <= 10) n1 += int'(req1_ready);
         next_cyc();
      end
      @(negedge clk);
      chk("bp_req0_issues", 33'(n0), 33'(4));
      chk("bp_req0_blocked", 33'(req0_ready), 33'(0));
      chk("bp_req1_streams", 33'(n1), 33'(4));
      next_cyc();
      resp0_ready = 1'b1;
      req1_valid  = 1'b0;
      n0 = 0;
      for (int k = 0; k < 10; k++) begin
         drive0(1'b1, OP_SUB, 32'h40C00000 + k, 32'h3F000000);
         @(negedge clk);
         n0 += int'(req0_ready);
         next_cyc();
      end
      chk("bp_resume", 33'(n0 > 0), 33'(1));
      req0_valid = 1'b0;
      repeat (8) next_cyc();

      // overflow passthrough
      drive0(1'b1, OP_SUB, 32'h7F7FFFFF, 32'hFF7FFFFF);
      next_cyc();
      req0_valid = 1'b0;
      repeat (3) next_cyc();
      @(negedge clk);
      chk("ovf_result", {resp0_ovf, resp0_y}, {1'b1, 32'h7F800000});
      next_cyc();

      // reset while an op is in flight
      drive0(1'b1, OP_SUB, 32'h40E00000, 32'h3F800000);
      @(negedge clk);
      chk("rmid_issue", 33'(req0_ready), 33'(1));
      next_cyc();
      req0_valid = 1'b0;
      next_cyc();
      rstn = 1'b0;
      next_cyc();
      rstn = 1'b1;
      resp0_ready = 1'b0;
      drive0(1'b1, OP_SUB, 32'h41100000, 32'h40000000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rmid_credit", 33'(req0_ready), 33'(k < 4));
         if (k < 4) chk("rmid_no_stale", 33'(resp0_valid), 33'(0));
         next_cyc();
      end
      req0_valid  = 1'b0;
      resp0_ready = 1'b1;
      repeat (8) next_cyc();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
